aux_text_fetcher: RTL

AUX_TEXT_FETCHER -- requirements
Module: aux_text_fetcher

---
 rtl/aux_text_fetcher.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/aux_text_fetcher.sv
// aux_text_fetcher: fetches three aux words per text line during horizontal blanking and renders them as hex digit cells.
// Optional macro AUX_TEXT_HIGHLIGHT_EN adds a highlight on row 4 of groups 1 and 2.
module aux_text_fetcher #(
   parameter int DATA_WIDTH        = 16,
   parameter int AUX_ADDRESS_WIDTH = 5,
   parameter int ELEMENTS          = 10,
   parameter int COORD_WIDTH       = 10,
   parameter int X_START           = 224,
   parameter int Y_START           = 160
) (
   input  logic                         clock_in,
   input  logic                         reset_in,
   input  logic [COORD_WIDTH-1:0]       pixel_x_in,
   input  logic [COORD_WIDTH-1:0]       pixel_y_in,
   input  logic                         video_on_in,
   input  logic [DATA_WIDTH-1:0]        aux_data_in,
   output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
   output logic [3:0]                   nibble_out,
   output logic [3:0]                   glyph_row_out,
   output logic [2:0]                   glyph_col_out,
   output logic                         char_valid_out,
   output logic                         highlight_out
);
   localparam int CW = COORD_WIDTH + 1;
   localparam int AW = AUX_ADDRESS_WIDTH;
   localparam logic [CW-1:0] XS     = CW'(X_START);
   localparam logic [CW-1:0] YS     = CW'(Y_START);
   localparam logic [CW-1:0] AREA_W = CW'(192);
   localparam logic [CW-1:0] AREA_H = CW'(16 * ELEMENTS);
   localparam logic [AW-1:0] GROUP1 = AW'(ELEMENTS);
   localparam logic [AW-1:0] GROUP2 = AW'(2 * ELEMENTS);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, LATCH} state_t;

   state_t                state_q, state_d;
   logic [1:0]            g_q, g_d;
   logic [AW-1:0]         row_q, row_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  vid_prev_q, vid_prev_d;
   logic [DATA_WIDTH-1:0] stage_q [2];
   logic [DATA_WIDTH-1:0] stage_d [2];
   logic [DATA_WIDTH-1:0] word_q [3];
   logic [DATA_WIDTH-1:0] word_d [3];
   logic [CW-1:0]         next_off, dx, dy;
   logic                  fall, rise;

   logic                  s1_valid_q, s1_valid_d;
   logic [1:0]            s1_group_q, s1_group_d;
   logic [1:0]            s1_digit_q, s1_digit_d;
   logic [3:0]            s1_row_q, s1_row_d;
   logic [2:0]            s1_col_q, s1_col_d;
   logic [DATA_WIDTH-1:0] sel_word;
   logic [3:0]            nibble_q, nibble_d;
   logic [3:0]            glyph_row_q, glyph_row_d;
   logic [2:0]            glyph_col_q, glyph_col_d;
   logic                  char_valid_q, char_valid_d;

   // Line fetch: one ADDR/WAIT/LATCH pass per group; the three words commit together so an aborted fetch leaves the line intact
   always_comb begin
      next_off   = {1'b0, pixel_y_in} + CW'(1) - YS;
      fall       = vid_prev_q & ~video_on_in;
      rise       = ~vid_prev_q & video_on_in;
      vid_prev_d = video_on_in;
      state_d    = state_q;
      g_d        = g_q;
      row_d      = row_q;
      addr_d     = addr_q;
      stage_d    = stage_q;
      word_d     = word_q;
      case (state_q)
         IDLE: if (fall && next_off < AREA_H) begin
            state_d = ADDR;
            row_d   = AW'(next_off >> 4);
            addr_d  = AW'(next_off >> 4);
         end
         ADDR: state_d = WAIT;
         WAIT: state_d = LATCH;
         default: begin
            if (g_q == 2'd2) begin
               word_d[0] = stage_q[0];
               word_d[1] = stage_q[1];
               word_d[2] = aux_data_in;
               g_d       = 2'd0;
               state_d   = IDLE;
            end else begin
               stage_d[g_q[0]] = aux_data_in;
               g_d             = g_q + 2'd1;
               addr_d          = row_q + (g_q[0] ? GROUP2 : GROUP1);
               state_d         = ADDR;
            end
         end
      endcase
      if (rise && state_q != IDLE) begin
         state_d = IDLE;
         g_d     = 2'd0;
         addr_d  = addr_q;
         word_d  = word_q;
      end
   end

   // Fetch state, read address, line words and previous video_on
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q    <= IDLE;
         g_q        <= '0;
         row_q      <= '0;
         addr_q     <= '0;
         vid_prev_q <= 1'b0;
         stage_q    <= '{default: '0};
         word_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         vid_prev_q <= vid_prev_d;
         stage_q    <= stage_d;
         word_q     <= word_d;
      end
   end

   // Stage 1: locate the pixel; offsets are one bit wider so coordinates left of or above the area wrap far outside it
   always_comb begin
      dx         = {1'b0, pixel_x_in} - XS;
      dy         = {1'b0, pixel_y_in} - YS;
      s1_valid_d = video_on_in && dx < AREA_W && !dx[5] && dy < AREA_H;
      s1_group_d = dx[7:6];
      s1_digit_d = dx[4:3];
      s1_col_d   = dx[2:0];
      s1_row_d   = dy[3:0];
   end

   // Stage 2: pick the digit from the line word, zero everything outside a cell
   always_comb begin
      sel_word     = s1_group_q == 2'd2 ? word_q[2] : s1_group_q == 2'd1 ? word_q[1] : word_q[0];
      nibble_d     = s1_valid_q ? 4'(sel_word >> (DATA_WIDTH - 4 - 4 * int'(s1_digit_q))) : 4'd0;
      glyph_row_d  = s1_valid_q ? s1_row_q : 4'd0;
      glyph_col_d  = s1_valid_q ? s1_col_q : 3'd0;
      char_valid_d = s1_valid_q;
   end

   // Render pipeline registers
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         s1_valid_q   <= 1'b0;
         s1_group_q   <= '0;
         s1_digit_q   <= '0;
         s1_row_q     <= '0;
         s1_col_q     <= '0;
         nibble_q     <= '0;
         glyph_row_q  <= '0;
         glyph_col_q  <= '0;
         char_valid_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_group_q   <= s1_group_d;
         s1_digit_q   <= s1_digit_d;
         s1_row_q     <= s1_row_d;
         s1_col_q     <= s1_col_d;
         nibble_q     <= nibble_d;
         glyph_row_q  <= glyph_row_d;
         glyph_col_q  <= glyph_col_d;
         char_valid_q <= char_valid_d;
      end
   end

`ifdef AUX_TEXT_HIGHLIGHT_EN
   logic s1_hl_q, s1_hl_d;
   logic highlight_q, highlight_d;

   // Row 4 of the memory-window groups marks the target entry
   always_comb begin
      s1_hl_d     = (dy >> 4) == CW'(4) && dx[7:6] != 2'd0;
      highlight_d = s1_valid_q & s1_hl_q;
   end

   // Highlight flag travels alongside the render pipeline
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         s1_hl_q     <= 1'b0;
         highlight_q <= 1'b0;
      end else begin
         s1_hl_q     <= s1_hl_d;
         highlight_q <= highlight_d;
      end
   end

   assign highlight_out = highlight_q;
`else
   assign highlight_out = 1'b0;
`endif

   assign aux_raddress_out = addr_q;
   assign nibble_out       = nibble_q;
   assign glyph_row_out    = glyph_row_q;
   assign glyph_col_out    = glyph_col_q;
   assign char_valid_out   = char_valid_q;
endmodule
